pcm_sampler: RTL and testbench

Downstream consumer of the PCM clock-crossing FIFO, in the 36 MHz domain. Pops DW-bit PCM symbols from the FIFO read port, packs them MSB-first into SW-bit samples, and releases one sample per sample-rate tick (every DIV cycles) to the DAC/output stage. Underruns are flagged and the previous sample is repeated, so the output cadence never breaks.

---
 rtl/pcm_pkg.sv | 14 +
 rtl/pcm_tickgen.sv | 34 +++
 rtl/pcm_sampler.sv | 141 ++++++++++++++
 tb/tb_pcm_sampler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// Shared definitions for the PCM sampling path: default symbol and sample
// widths, the 48 kHz divider for a 36 MHz clock, and the sampler FSM states.
package pcm_pkg;

  localparam int PCM_DW      = 2;
  localparam int PCM_SW      = 16;
  localparam int PCM_DIV_48K = 750;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } pcm_smp_state_t;

endpackage

// File: rtl/pcm_tickgen.sv
// Sample-rate tick generator for the 36 MHz domain.
// Counts 0..DIV-1 while enabled and pulses o_tick on the last count, so ticks
// are exactly DIV cycles apart and the first one lands DIV cycles after i_en
// rises. Dropping i_en clears the counter so the phase restarts cleanly.
module pcm_tickgen
  import pcm_pkg::*;
#(
  parameter int DIV = PCM_DIV_48K
) (
  input  logic i_clk36,
  input  logic i_rst36_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int              DIVW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

  logic [DIVW-1:0] div;

  assign o_tick = i_en && (div == DIV_LAST);

  // Free-running divider, held at zero whenever the block is disabled
  always_ff @(posedge i_clk36 or negedge i_rst36_n) begin
    if (!i_rst36_n) begin
      div <= '0;
    end else if (!i_en || (div == DIV_LAST)) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/pcm_sampler.sv
// PCM sampler: drains the first-word-fall-through PCM FIFO, packs DW-bit
// symbols MSB-first into SW-bit samples and releases one sample per
// sample-rate tick. A tick that finds no complete sample repeats the previous
// sample and raises o_underrun, so the output cadence never breaks.
// Optional feature: define PCMSAMPLER_UNDERRUN_CNT_EN to add the saturating
// 16-bit underrun counter on o_underrun_cnt.
module pcm_sampler
  import pcm_pkg::*;
#(
  parameter int DW  = PCM_DW,
  parameter int SW  = PCM_SW,
  parameter int DIV = PCM_DIV_48K
) (
  input  logic          i_clk36,
  input  logic          i_rst36_n,
  input  logic          i_en,
  input  logic          i_empty,
  input  logic [DW-1:0] i_dout,
  output logic          o_rdreq,
  output logic [SW-1:0] o_sample,
  output logic          o_strobe,
`ifdef PCMSAMPLER_UNDERRUN_CNT_EN
  output logic          o_underrun,
  output logic [15:0]   o_underrun_cnt
`else
  output logic          o_underrun
`endif
);

  localparam int            NBEAT     = SW / DW;
  localparam int            BW        = $clog2(NBEAT) + 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(NBEAT - 1);

  pcm_smp_state_t state;
  pcm_smp_state_t state_nxt;

  logic [SW-1:0] shreg;
  logic [BW-1:0] beat;
  logic          tick;
  logic          pop;
  logic          release_evt;
  logic          underrun_evt;

  pcm_tickgen #(
    .DIV (DIV)
  ) u_tickgen (
    .i_clk36   (i_clk36),
    .i_rst36_n (i_rst36_n),
    .i_en      (i_en),
    .o_tick    (tick)
  );

  // A tick either hands over a finished sample or, while still filling,
  // reports an underrun; a last pop coinciding with the tick still counts
  // as an underrun because the sample was not ready at that edge.
  assign release_evt  = tick && (state == READY);
  assign underrun_evt = tick && (state == FILL);
  assign o_rdreq      = pop;

  // FSM state register
  always_ff @(posedge i_clk36 or negedge i_rst36_n) begin
    if (!i_rst36_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and FIFO pop; the pop is combinational because the FIFO
  // presents its head word before the read request
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      FILL: begin
        pop = i_en && !i_empty;
        if (pop && (beat == BEAT_LAST)) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (tick) begin
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Symbol packer: shift in MSB-first on each pop, rewind the beat count
  // once the finished sample has been handed over. A partial sample left by
  // an underrun simply keeps filling.
  always_ff @(posedge i_clk36 or negedge i_rst36_n) begin
    if (!i_rst36_n) begin
      shreg <= '0;
      beat  <= '0;
    end else if (pop) begin
      shreg <= {shreg[SW-DW-1:0], i_dout};
      beat  <= beat + 1'b1;
    end else if (release_evt) begin
      beat  <= '0;
    end
  end

  // Output stage: strobe on every tick, new sample only when one is ready
  always_ff @(posedge i_clk36 or negedge i_rst36_n) begin
    if (!i_rst36_n) begin
      o_sample   <= '0;
      o_strobe   <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_strobe   <= tick;
      o_underrun <= underrun_evt;
      if (release_evt) begin
        o_sample <= shreg;
      end
    end
  end

`ifdef PCMSAMPLER_UNDERRUN_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  logic [15:0] underrun_cnt;

  // Underrun counter, sticks at full scale instead of wrapping
  always_ff @(posedge i_clk36 or negedge i_rst36_n) begin
    if (!i_rst36_n) begin
      underrun_cnt <= '0;
    end else if (underrun_evt) begin
      underrun_cnt <= sat_inc16(underrun_cnt);
    end
  end

  assign o_underrun_cnt = underrun_cnt;
`endif

endmodule

// File: tb/tb_pcm_sampler.sv
// Directed bench for pcm_sampler with DIV=8, SW=16, DW=2 and a small
// first-word-fall-through FIFO model feeding it.
// Counter checks are compiled in when PCMSAMPLER_UNDERRUN_CNT_EN is defined.
module tb_pcm_sampler;

  localparam int DW  = 2;
  localparam int SW  = 16;
  localparam int DIV = 8;

  logic          i_clk36 = 1'b0;
  logic          i_rst36_n;
  logic          i_en;
  logic          i_empty;
  logic [DW-1:0] i_dout;
  logic          o_rdreq;
  logic [SW-1:0] o_sample;
  logic          o_strobe;
  logic          o_underrun;
`ifdef PCMSAMPLER_UNDERRUN_CNT_EN
  logic [15:0]   o_underrun_cnt;
`endif

  logic [DW-1:0] q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  pcm_sampler #(
    .DW  (DW),
    .SW  (SW),
    .DIV (DIV)
  ) dut (
    .i_clk36    (i_clk36),
    .i_rst36_n  (i_rst36_n),
    .i_en       (i_en),
    .i_empty    (i_empty),
    .i_dout     (i_dout),
    .o_rdreq    (o_rdreq),
    .o_sample   (o_sample),
    .o_strobe   (o_strobe),
    .o_underrun (o_underrun)
`ifdef PCMSAMPLER_UNDERRUN_CNT_EN
    , .o_underrun_cnt (o_underrun_cnt)
`endif
  );

  always #5 i_clk36 = ~i_clk36;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_drive();
    i_empty = (q.size() == 0);
    i_dout  = (q.size() == 0) ? '0 : q[0];
  endtask

  // FIFO model: head consumed at the edge where the pop is asserted
  always @(posedge i_clk36) begin
    if (o_rdreq && (q.size() != 0)) void'(q.pop_front());
  end

  // FIFO model: present the new head away from the active edge
  always @(negedge i_clk36) fifo_drive();

  task automatic step();
    @(posedge i_clk36);
    @(negedge i_clk36);
    #1;
  endtask

  // Push n symbols taken MSB-first from w
  task automatic push_syms(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) q.push_back(w[15-2*i -: 2]);
    fifo_drive();
    #1;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_strobe && (n < 3 * DIV));
  endtask

  task automatic do_reset();
    i_en      = 1'b0;
    i_rst36_n = 1'b0;
    q.delete();
    fifo_drive();
    step();
    step();
    i_rst36_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int sc;

    // Reset state with an empty FIFO, then the first ticks
    i_en      = 1'b0;
    i_rst36_n = 1'b0;
    fifo_drive();
    step();
    step();
    check_val("rst_sample",   32'(o_sample),   32'h0);
    check_val("rst_strobe",   32'(o_strobe),   32'h0);
    check_val("rst_underrun", 32'(o_underrun), 32'h0);
    check_val("rst_rdreq",    32'(o_rdreq),    32'h0);
`ifdef PCMSAMPLER_UNDERRUN_CNT_EN
    check_val("rst_cnt",      32'(o_underrun_cnt), 32'h0);
`endif
    i_rst36_n = 1'b1;
    i_en      = 1'b1;
    #1;
    check_val("empty_rdreq", 32'(o_rdreq), 32'h0);
    wait_strobe(n);
    check_val("first_tick_lat", 32'(n), 32'd8);
    check_val("first_tick_ur",  32'(o_underrun), 32'h1);
    check_val("first_tick_smp", 32'(o_sample), 32'h0);
    step();
    check_val("strobe_width", 32'(o_strobe), 32'h0);
    wait_strobe(n);
    check_val("tick_period", 32'(n), 32'd7);

    // Preloaded FIFO: 8 back-to-back pops, last one on the first tick
    do_reset();
    push_syms(16'hE4E4, 8);
    check_val("dis_rdreq", 32'(o_rdreq), 32'h0);
    i_en = 1'b1;
    #1;
    check_val("pre_rdreq", 32'(o_rdreq), 32'h1);
    wait_strobe(n);
    check_val("pre_tick1_lat", 32'(n), 32'd8);
    check_val("pre_tick1_ur",  32'(o_underrun), 32'h1);
    check_val("pre_tick1_smp", 32'(o_sample), 32'h0);
    check_val("pre_popped",    32'(q.size()), 32'd0);
    check_val("ready_rdreq",   32'(o_rdreq), 32'h0);
    wait_strobe(n);
    check_val("pre_tick2_lat", 32'(n), 32'd8);
    check_val("pre_tick2_ur",  32'(o_underrun), 32'h0);
    check_val("pre_tick2_smp", 32'(o_sample), 32'hE4E4);

    // Half a sample before the tick, the rest afterwards
    do_reset();
    push_syms(16'hE400, 4);
    i_en = 1'b1;
    wait_strobe(n);
    check_val("half_tick1_ur",  32'(o_underrun), 32'h1);
    check_val("half_tick1_smp", 32'(o_sample), 32'h0);
    push_syms(16'h0100, 4);
    wait_strobe(n);
    check_val("half_tick2_lat", 32'(n), 32'd8);
    check_val("half_tick2_ur",  32'(o_underrun), 32'h0);
    check_val("half_tick2_smp", 32'(o_sample), 32'hE401);
    wait_strobe(n);
    check_val("repeat_ur",  32'(o_underrun), 32'h1);
    check_val("repeat_smp", 32'(o_sample), 32'hE401);

    // Enable dropped mid-fill for 20 cycles
    do_reset();
    push_syms(16'h55AA, 8);
    i_en = 1'b1;
    step();
    step();
    step();
    i_en = 1'b0;
    #1;
    check_val("hold_rdreq", 32'(o_rdreq), 32'h0);
    sc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_strobe) sc++;
    end
    check_val("hold_strobes", 32'(sc), 32'd0);
    check_val("hold_fifo",    32'(q.size()), 32'd5);
    check_val("hold_div",     32'(dut.u_tickgen.div), 32'd0);
    i_en = 1'b1;
    #1;
    check_val("resume_rdreq", 32'(o_rdreq), 32'h1);
    wait_strobe(n);
    check_val("resume_lat", 32'(n), 32'd8);
    check_val("resume_ur",  32'(o_underrun), 32'h0);
    check_val("resume_smp", 32'(o_sample), 32'h55AA);

    // Reset in the middle of a fill discards the partial sample
    do_reset();
    push_syms(16'hFC00, 3);
    i_en = 1'b1;
    step();
    step();
    step();
    i_en      = 1'b0;
    i_rst36_n = 1'b0;
    q.delete();
    fifo_drive();
    #1;
    check_val("midrst_strobe", 32'(o_strobe), 32'h0);
    step();
    i_rst36_n = 1'b1;
    push_syms(16'h0002, 8);
    i_en = 1'b1;
    wait_strobe(n);
    check_val("midrst_tick1_ur", 32'(o_underrun), 32'h1);
    wait_strobe(n);
    check_val("midrst_tick2_ur",  32'(o_underrun), 32'h0);
    check_val("midrst_tick2_smp", 32'(o_sample), 32'h0002);

`ifdef PCMSAMPLER_UNDERRUN_CNT_EN
    // Underrun counter: three empty ticks, then saturation
    do_reset();
    i_en = 1'b1;
    wait_strobe(n);
    wait_strobe(n);
    wait_strobe(n);
    check_val("cnt_three", 32'(o_underrun_cnt), 32'd3);
    force dut.underrun_cnt = 16'hFFFF;
    #1;
    release dut.underrun_cnt;
    #1;
    check_val("cnt_forced", 32'(o_underrun_cnt), 32'hFFFF);
    wait_strobe(n);
    check_val("cnt_sat_ur", 32'(o_underrun), 32'h1);
    check_val("cnt_sat",    32'(o_underrun_cnt), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
